// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads word-addressed instruction memory,
// and hands each fetched word to decode over a valid/ready handshake.
module instr_fetch_unit #(
   parameter int unsigned        AWIDTH    = 15,
   parameter int unsigned        DWIDTH    = 32,
   parameter logic [AWIDTH-1:0]  RESET_PC  = '0,
   parameter logic [DWIDTH-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_rd,
   output logic [AWIDTH-1:0] mem_addr,
   input  logic [DWIDTH-1:0] mem_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DWIDTH-1:0] instr,
   output logic [AWIDTH-1:0] instr_pc,
   input  logic              redirect_valid,
   input  logic [AWIDTH-1:0] redirect_pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_VALID,
      ST_HALTED
   } state_t;

   state_t              state,       state_n;
   logic [AWIDTH-1:0]   pc,          pc_n;
   logic                mem_rd_n;
   logic                instr_valid_n;
   logic [DWIDTH-1:0]   instr_n;
   logic [AWIDTH-1:0]   instr_pc_n;
   logic                halted_n;

   // The address register is the PC itself, so it holds through REQ and WAIT.
   assign mem_addr = pc;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         mem_rd      <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         halted      <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         mem_rd      <= mem_rd_n;
         instr_valid <= instr_valid_n;
         instr       <= instr_n;
         instr_pc    <= instr_pc_n;
         halted      <= halted_n;
      end
   end

   // Next-state and next-output logic; redirect outranks the decode handshake.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      instr_valid_n = instr_valid;
      instr_n       = instr;
      instr_pc_n    = instr_pc;
      halted_n      = halted;

      case (state)
         ST_IDLE: begin
            if (redirect_valid) pc_n = redirect_pc;
            if (start)          state_n = ST_REQ;
         end
         ST_REQ: begin
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               state_n = ST_REQ;
            end else begin
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               state_n = ST_REQ;
            end else begin
               instr_n       = mem_data;
               instr_pc_n    = pc;
               instr_valid_n = 1'b1;
               state_n       = ST_VALID;
            end
         end
         ST_VALID: begin
            if (redirect_valid) begin
               pc_n          = redirect_pc;
               instr_valid_n = 1'b0;
               state_n       = ST_REQ;
            end else if (instr_ready) begin
               instr_valid_n = 1'b0;
               if (instr == HALT_WORD) begin
                  halted_n = 1'b1;
                  state_n  = ST_HALTED;
               end else begin
                  pc_n    = pc + AWIDTH'(1);
                  state_n = ST_REQ;
               end
            end
         end
         ST_HALTED: begin
            instr_valid_n = 1'b0;
            halted_n      = 1'b1;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      mem_rd_n = (state_n == ST_REQ);
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle-latency instruction memory model.
module tb_instr_fetch_unit;

   localparam int unsigned AW = 15;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data = '0;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          halted;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int vectors    = 0;
   int miscompares = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .mem_rd         (mem_rd),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   // Data is returned on the edge after the strobe, valid through the wait cycle.
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hDEAD_0000 | 32'(i);
      mem[0]       = 32'h0000_0001;
      mem[1]       = 32'h0000_002A;
      mem[2]       = 32'hFFFF_FFFF;
      mem[16'h10]  = 32'h0000_0100;
      mem[15'h7FFF] = 32'h0000_7777;

      rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();
      chk("rst_mem_rd",   32'(mem_rd), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_valid",    32'(instr_valid), 0);
      chk("rst_instr",    instr, 0);
      chk("rst_instr_pc", 32'(instr_pc), 0);
      chk("rst_halted",   32'(halted), 0);

      // Basic fetch, ready tied high
      rst_n = 1'b1; start = 1'b1; instr_ready = 1'b1;
      tick(); start = 1'b0;
      chk("b_req0_rd",   32'(mem_rd), 1);
      chk("b_req0_addr", 32'(mem_addr), 0);
      chk("b_req0_vld",  32'(instr_valid), 0);
      tick();
      chk("b_wait0_rd",  32'(mem_rd), 0);
      tick();
      chk("b_v0_vld",    32'(instr_valid), 1);
      chk("b_v0_instr",  instr, 32'h1);
      chk("b_v0_pc",     32'(instr_pc), 0);
      chk("b_v0_rd",     32'(mem_rd), 0);
      tick();
      chk("b_req1_rd",   32'(mem_rd), 1);
      chk("b_req1_addr", 32'(mem_addr), 1);
      chk("b_req1_vld",  32'(instr_valid), 0);
      tick();
      chk("b_wait1_rd",  32'(mem_rd), 0);
      tick();
      chk("b_v1_vld",    32'(instr_valid), 1);
      chk("b_v1_instr",  instr, 32'h2A);
      chk("b_v1_pc",     32'(instr_pc), 1);
      instr_ready = 1'b0;
      tick();
      chk("b_hold_vld",  32'(instr_valid), 1);
      chk("b_hold_instr", instr, 32'h2A);

      // Reset while an instruction is held
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("r_vld",    32'(instr_valid), 0);
      chk("r_halted", 32'(halted), 0);
      chk("r_addr",   32'(mem_addr), 0);
      chk("r_rd",     32'(mem_rd), 0);
      chk("r_instr",  instr, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("r_idle_rd",  32'(mem_rd), 0);
         chk("r_idle_vld", 32'(instr_valid), 0);
      end

      // Backpressure on the first instruction
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("bp_vld",   32'(instr_valid), 1);
      chk("bp_instr", instr, 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_vld",   32'(instr_valid), 1);
         chk("bp_hold_instr", instr, 32'h1);
         chk("bp_hold_pc",    32'(instr_pc), 0);
         chk("bp_hold_rd",    32'(mem_rd), 0);
         chk("bp_hold_addr",  32'(mem_addr), 0);
      end
      instr_ready = 1'b1;
      tick();
      chk("bp_next_rd",   32'(mem_rd), 1);
      chk("bp_next_addr", 32'(mem_addr), 1);
      chk("bp_next_vld",  32'(instr_valid), 0);

      // Redirect during WAIT of addr 1
      tick();
      chk("rd_wait_rd", 32'(mem_rd), 0);
      redirect_valid = 1'b1; redirect_pc = 15'h0010;
      tick(); redirect_valid = 1'b0;
      chk("rd_req_rd",   32'(mem_rd), 1);
      chk("rd_req_addr", 32'(mem_addr), 32'h10);
      chk("rd_req_vld",  32'(instr_valid), 0);
      tick();
      chk("rd_wait_vld", 32'(instr_valid), 0);
      tick();
      chk("rd_v_vld",   32'(instr_valid), 1);
      chk("rd_v_instr", instr, 32'h100);
      chk("rd_v_pc",    32'(instr_pc), 32'h10);

      // Redirect beats a same-cycle accept; then PC wraps
      redirect_valid = 1'b1; redirect_pc = 15'h7FFF;
      tick(); redirect_valid = 1'b0;
      chk("wr_req_rd",   32'(mem_rd), 1);
      chk("wr_req_addr", 32'(mem_addr), 32'h7FFF);
      chk("wr_req_vld",  32'(instr_valid), 0);
      tick(); tick();
      chk("wr_v_instr", instr, 32'h7777);
      chk("wr_v_pc",    32'(instr_pc), 32'h7FFF);
      tick();
      chk("wr_next_rd",   32'(mem_rd), 1);
      chk("wr_next_addr", 32'(mem_addr), 0);

      // Redirect in IDLE without start moves pc but does not fetch
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 15'h0010;
      tick(); redirect_valid = 1'b0;
      chk("ir_addr", 32'(mem_addr), 32'h10);
      chk("ir_rd",   32'(mem_rd), 0);

      // Redirect and start together in IDLE, then halt handling
      redirect_valid = 1'b1; redirect_pc = 15'h0002; start = 1'b1; instr_ready = 1'b0;
      tick(); redirect_valid = 1'b0; start = 1'b0;
      chk("h_req_rd",   32'(mem_rd), 1);
      chk("h_req_addr", 32'(mem_addr), 2);
      tick(); tick();
      chk("h_v_vld",    32'(instr_valid), 1);
      chk("h_v_instr",  instr, 32'hFFFF_FFFF);
      chk("h_v_pc",     32'(instr_pc), 2);
      chk("h_v_halted", 32'(halted), 0);
      redirect_valid = 1'b1; redirect_pc = 15'h0002;
      tick(); redirect_valid = 1'b0;
      chk("h_sq_vld",    32'(instr_valid), 0);
      chk("h_sq_halted", 32'(halted), 0);
      chk("h_sq_rd",     32'(mem_rd), 1);
      instr_ready = 1'b1;
      tick(); tick();
      chk("h_v2_instr", instr, 32'hFFFF_FFFF);
      tick();
      chk("h_halted", 32'(halted), 1);
      chk("h_vld",    32'(instr_valid), 0);
      chk("h_rd",     32'(mem_rd), 0);
      redirect_valid = 1'b1; redirect_pc = 15'h0005; start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("h_stay_rd",     32'(mem_rd), 0);
         chk("h_stay_halted", 32'(halted), 1);
         chk("h_stay_vld",    32'(instr_valid), 0);
         chk("h_stay_addr",   32'(mem_addr), 2);
      end
      redirect_valid = 1'b0; start = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("h_rst_halted", 32'(halted), 0);
      chk("h_rst_addr",   32'(mem_addr), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of decode and directly downstream of the processor's word-addressed instruction memory (AWIDTH=15, DWIDTH=32, separate wr/rd strobes).
- Holds the program counter, issues read strobes and addresses to memory, and captures the returned word.
- Presents each captured word to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) and stops fetching on a halt word.

Parameters:
AWIDTH, 15, instruction memory address width (words)
DWIDTH, 32, instruction word width
RESET_PC, 0, PC value after reset
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  leave IDLE and begin fetching at current pc
mem_rd  out  1  read strobe to instruction memory
mem_addr  out  AWIDTH  read address to instruction memory
mem_data  in  DWIDTH  read data from instruction memory
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr_ready  in  1  decode accepts instruction this cycle
instr  out  DWIDTH  fetched instruction word
instr_pc  out  AWIDTH  address the instruction was fetched from
redirect_valid  in  1  load new pc, squash current fetch
redirect_pc  in  AWIDTH  redirect target
halted  out  1  HALT_WORD fetched and accepted; fetch stopped

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - state=IDLE, pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0, halted=0.
  - Reset overrides everything, including mid-fetch and a held instruction, which is dropped.
- Memory timing contract: mem_data is sampled on the edge ending the cycle after the one in which mem_rd=1. mem_addr holds stable through both cycles.
- mem_rd is high only in REQ. The wr strobe is never driven by this block.
- IDLE: mem_rd=0. start=1 -> REQ.
- REQ: mem_rd=1, mem_addr=pc. Next state is WAIT.
- WAIT: mem_rd=0, mem_addr=pc. At the end of the cycle:
  - instr<=mem_data, instr_pc<=pc, instr_valid<=1.
  - Next state is VALID.
- VALID: instr_valid=1; instr and instr_pc are held stable while instr_ready=0. On instr_valid & instr_ready:
  - If instr==HALT_WORD: instr_valid<=0, halted<=1, state becomes HALTED.
  - Otherwise: instr_valid<=0, pc<=pc+1, state becomes REQ.
- HALTED: mem_rd=0, instr_valid=0, halted=1. Only reset exits; redirect_valid and start are ignored.
- Latency and throughput:
  - First instr_valid appears 3 cycles after start is sampled (IDLE->REQ->WAIT->VALID).
  - With instr_ready tied high, one instruction is delivered every 3 cycles.
- Redirect, when redirect_valid=1 in REQ, WAIT or VALID:
  - pc<=redirect_pc, instr_valid<=0, state becomes REQ.
  - The in-flight read is discarded: mem_data is not captured in WAIT.
  - Redirect has priority over a same-cycle handshake; the accepted instruction is still consumed by decode, but pc takes redirect_pc, not pc+1.
- Redirect in IDLE: pc<=redirect_pc and state stays IDLE. If start=1 in the same cycle, go to REQ using redirect_pc.
- PC arithmetic: pc+1 is modulo 2^AWIDTH, so 0x7FFF wraps to 0x0000 with no flag.
- start is ignored outside IDLE.
- HALT_WORD takes effect only after it is accepted. A redirect arriving while it is still held squashes it, and no halt occurs.

Test Plan:
- Basic fetch: memory model preloaded with addr0=32'h0000_0001, addr1=32'h0000_002A; reset, start pulse, instr_ready=1 -> instr=1/instr_pc=0, then instr=0x2A/instr_pc=1, 3 cycles apart; mem_rd high exactly one cycle per fetch.
- Backpressure: instr_ready=0 for 5 cycles after first instr_valid -> instr and instr_pc stable, mem_rd stays 0, pc stays 0. Raise instr_ready -> the next fetch is at addr 1.
- Redirect: redirect_valid=1, redirect_pc=0x0010 during WAIT of addr 1 -> addr-1 data never appears on instr; next mem_addr=0x0010; next instr_pc=0x0010.
- Halt: addr2=32'hFFFF_FFFF -> instr=FFFF_FFFF presented; after accept, halted=1 and mem_rd stays 0 for 20 cycles; redirect_valid is ignored.
- Wrap-around: redirect to 0x7FFF, accept its instruction -> next mem_addr=0x0000.
- Reset mid-operation: rst_n=0 for one edge while in VALID -> instr_valid=0, halted=0, mem_addr=RESET_PC, state IDLE; no fetch occurs until the next start.
